// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: idle arbitration, fetch grant, data grant.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Width of the fetch starvation counter (saturates at all-ones).
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter sharing one memory port.
// Data wins by default; fetch is forced through after MAX_WAIT lost rounds.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              iack_o,
  output logic [DATA_W-1:0] irdata_o,
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic              dack_o,
  output logic [DATA_W-1:0] drdata_o,
  output logic              mem_en_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_busy_i
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  arb_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  i_force;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Fetch has been starved long enough that it must win this arbitration.
  assign i_force = ireq_i && (wait_cnt_q >= MAX_WAIT_C);

  // State and starvation counter registers; reset abandons any access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state, counter update and all port outputs.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    iack_o      = 1'b0;
    irdata_o    = '0;
    dack_o      = 1'b0;
    drdata_o    = '0;
    mem_en_o    = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (dreq_i && !i_force) begin
          state_d = GNT_D;
          if (ireq_i) wait_cnt_d = sat_inc(wait_cnt_q);
        end else if (ireq_i) begin
          state_d    = GNT_I;
          wait_cnt_d = '0;
        end
      end

      GNT_I: begin
        if (ireq_i) begin
          mem_en_o   = 1'b1;
          mem_addr_o = iaddr_i;
          if (!mem_busy_i) begin
            iack_o   = 1'b1;
            irdata_o = mem_rdata_i;
            state_d  = IDLE;
          end
        end else begin
          // Request withdrawn mid-grant: abandon silently.
          state_d = IDLE;
        end
      end

      GNT_D: begin
        if (dreq_i) begin
          mem_en_o   = 1'b1;
          mem_addr_o = daddr_i;
          if (dwe_i) begin
            // Writes commit at the edge, so busy does not hold them off.
            mem_wen_o   = 1'b1;
            mem_wdata_o = dwdata_i;
            dack_o      = 1'b1;
            state_d     = IDLE;
          end else if (!mem_busy_i) begin
            dack_o   = 1'b1;
            drdata_o = mem_rdata_i;
            state_d  = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (!ireq_i) wait_cnt_d = '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              ireq_i;
  logic [ADDR_W-1:0] iaddr_i;
  logic              iack_o;
  logic [DATA_W-1:0] irdata_o;
  logic              dreq_i;
  logic              dwe_i;
  logic [ADDR_W-1:0] daddr_i;
  logic [DATA_W-1:0] dwdata_i;
  logic              dack_o;
  logic [DATA_W-1:0] drdata_o;
  logic              mem_en_o;
  logic              mem_wen_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_busy_i;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .iack_o(iack_o), .irdata_o(irdata_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
    .dack_o(dack_o), .drdata_o(drdata_o),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_busy_i(mem_busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Every output in one call: used where the arbiter must be fully quiet.
  task automatic check_quiet(input string tag);
    check_eq({tag, "_en"},    32'(mem_en_o), 32'd0);
    check_eq({tag, "_wen"},   32'(mem_wen_o), 32'd0);
    check_eq({tag, "_addr"},  mem_addr_o, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check_eq({tag, "_iack"},  32'(iack_o), 32'd0);
    check_eq({tag, "_dack"},  32'(dack_o), 32'd0);
    check_eq({tag, "_ird"},   irdata_o, 32'd0);
    check_eq({tag, "_drd"},   drdata_o, 32'd0);
  endtask

  int ack_cnt;
  int d_acks;
  int i_acks;

  initial begin
    rst_i = 1'b1; ireq_i = 1'b1; iaddr_i = 32'h10; dreq_i = 1'b1; dwe_i = 1'b1;
    daddr_i = 32'h20; dwdata_i = 32'hA5A5A5A5; mem_rdata_i = 32'h11111111; mem_busy_i = 1'b0;

    // Reset: outputs quiet even with requests present.
    cyc(); cyc();
    #1;
    check_quiet("reset");
    ireq_i = 1'b0; dreq_i = 1'b0; dwe_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    #1;
    check_quiet("idle");

    // Lone fetch.
    cyc();
    ireq_i = 1'b1; iaddr_i = 32'h10; mem_rdata_i = 32'hDEADBEEF;
    #1;
    check_eq("fetch_arb_en", 32'(mem_en_o), 32'd0);
    cyc(); #1;
    check_eq("fetch_en",    32'(mem_en_o), 32'd1);
    check_eq("fetch_wen",   32'(mem_wen_o), 32'd0);
    check_eq("fetch_addr",  mem_addr_o, 32'h10);
    check_eq("fetch_ack",   32'(iack_o), 32'd1);
    check_eq("fetch_data",  irdata_o, 32'hDEADBEEF);
    cyc();
    ireq_i = 1'b0;
    #1;
    check_eq("fetch_after_en", 32'(mem_en_o), 32'd0);
    check_eq("fetch_after_ack", 32'(iack_o), 32'd0);

    // Busy-stalled read.
    cyc();
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h4000; mem_rdata_i = 32'hCAFEF00D;
    #1;
    check_eq("rd_arb_en", 32'(mem_en_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      mem_busy_i = 1'b1;
      #1;
      check_eq("rd_busy_en",   32'(mem_en_o), 32'd1);
      check_eq("rd_busy_addr", mem_addr_o, 32'h4000);
      check_eq("rd_busy_ack",  32'(dack_o), 32'd0);
      check_eq("rd_busy_data", drdata_o, 32'd0);
    end
    cyc();
    mem_busy_i = 1'b0;
    #1;
    check_eq("rd_en",   32'(mem_en_o), 32'd1);
    check_eq("rd_ack",  32'(dack_o), 32'd1);
    check_eq("rd_data", drdata_o, 32'hCAFEF00D);
    cyc();
    dreq_i = 1'b0;
    #1;
    check_eq("rd_after_en", 32'(mem_en_o), 32'd0);

    // Write with busy high throughout (busy in IDLE also ignored).
    cyc();
    dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h4004; dwdata_i = 32'h12345678; mem_busy_i = 1'b1;
    #1;
    check_eq("wr_arb_wen", 32'(mem_wen_o), 32'd0);
    cyc(); #1;
    check_eq("wr_en",    32'(mem_en_o), 32'd1);
    check_eq("wr_wen",   32'(mem_wen_o), 32'd1);
    check_eq("wr_ack",   32'(dack_o), 32'd1);
    check_eq("wr_addr",  mem_addr_o, 32'h4004);
    check_eq("wr_wdata", mem_wdata_o, 32'h12345678);
    // Request kept one cycle longer: must see an IDLE gap, not a second write.
    cyc(); #1;
    check_eq("wr_gap_wen", 32'(mem_wen_o), 32'd0);
    check_eq("wr_gap_ack", 32'(dack_o), 32'd0);
    check_eq("wr_gap_en",  32'(mem_en_o), 32'd0);
    // That held request is granted again; withdraw it inside the grant.
    cyc();
    dreq_i = 1'b0;
    #1;
    check_quiet("drop");
    cyc();
    dwe_i = 1'b0; mem_busy_i = 1'b0;
    #1;
    check_quiet("drop_idle");

    // Starvation: both requests held; expect D D D D I repeating.
    cyc();
    ireq_i = 1'b1; iaddr_i = 32'h100; dreq_i = 1'b1; daddr_i = 32'h200;
    mem_rdata_i = 32'h0BADF00D;
    ack_cnt = 0; d_acks = 0; i_acks = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (iack_o || dack_o) begin
        check_eq("starve_iack", 32'(iack_o), (ack_cnt % 5 == 4) ? 32'd1 : 32'd0);
        check_eq("starve_dack", 32'(dack_o), (ack_cnt % 5 == 4) ? 32'd0 : 32'd1);
        check_eq("starve_addr", mem_addr_o, (ack_cnt % 5 == 4) ? 32'h100 : 32'h200);
        if (iack_o) i_acks++;
        if (dack_o) d_acks++;
        ack_cnt++;
      end
      cyc();
    end
    check_eq("starve_acks",   32'(ack_cnt), 32'd10);
    check_eq("starve_i_acks", 32'(i_acks), 32'd2);
    check_eq("starve_d_acks", 32'(d_acks), 32'd8);
    ireq_i = 1'b0; dreq_i = 1'b0;
    #1;
    check_eq("starve_end_en", 32'(mem_en_o), 32'd0);

    // Reset in the middle of a stalled read.
    cyc();
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h4008; mem_busy_i = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    cyc(); #1;
    check_eq("rst_mid_en", 32'(mem_en_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_quiet("rst_mid");
    cyc();
    rst_i = 1'b0; mem_busy_i = 1'b0;
    #1;
    check_eq("rst_rel_en",  32'(mem_en_o), 32'd0);
    check_eq("rst_rel_ack", 32'(dack_o), 32'd0);
    cyc(); #1;
    check_eq("rst_fresh_ack",  32'(dack_o), 32'd1);
    check_eq("rst_fresh_data", drdata_o, 32'h55AA55AA);
    cyc();
    dreq_i = 1'b0;
    #1;
    check_quiet("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port memory model between an instruction-fetch requester (I) and a data load/store requester (D).
- Sequences each access against the memory's busy/stall signal and returns per-requester acknowledge and read data.
- Lets fetch and data traffic share a single port when the core is built against a single-port memory view, freeing port 2 for the testbench or DMA.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive cycles I may lose arbitration before it is forced to win; range 1..15

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ireq_i  in  1  instruction-fetch request (read only); held until iack_o
- iaddr_i  in  ADDR_W  fetch address
- iack_o  out  1  fetch complete; irdata_o valid this cycle
- irdata_o  out  DATA_W  fetch data
- dreq_i  in  1  data request; held until dack_o
- dwe_i  in  1  1 = write, 0 = read; held with dreq_i
- daddr_i  in  ADDR_W  data address
- dwdata_i  in  DATA_W  write data
- dack_o  out  1  data access complete
- drdata_o  out  DATA_W  load data, valid with dack_o when dwe_i = 0
- mem_en_o  out  1  memory port enable
- mem_wen_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data (combinational)
- mem_busy_i  in  1  memory stall; read data invalid while high

Behaviour:
- Reset: asynchronous on rst_i high. State goes to IDLE, wait counter = 0. Every output is 0 while in reset and in IDLE.
- States: IDLE, GNT_I, GNT_D.
- IDLE arbitration, evaluated each cycle:
  - D wins when dreq_i = 1, unless ireq_i = 1 and wait_cnt >= MAX_WAIT; in that case I wins.
  - Otherwise I wins if ireq_i = 1.
  - Winner's state is entered at the next edge.
- wait_cnt (4-bit, saturating):
  - Increments on each IDLE cycle in which ireq_i = 1 and D wins.
  - Clears when GNT_I is entered.
  - Clears when ireq_i = 0.
- GNT_I:
  - Drives mem_en_o = 1, mem_wen_o = 0, mem_addr_o = iaddr_i.
  - iack_o = ~mem_busy_i & ireq_i, with irdata_o = mem_rdata_i on that cycle; irdata_o is 0 otherwise.
  - Returns to IDLE on the edge after iack_o.
- GNT_D, read (dwe_i = 0): same as GNT_I but using the D signals (daddr_i, dack_o, drdata_o).
- GNT_D, write (dwe_i = 1):
  - mem_wen_o = 1 and mem_wdata_o = dwdata_i for exactly one cycle; mem_busy_i is ignored because writes commit at the edge.
  - dack_o = 1 in that same cycle; return to IDLE.
- Latency:
  - Minimum 2 cycles from request to ack: 1 IDLE arbitration cycle plus 1 grant cycle.
  - Each cycle of mem_busy_i adds 1.
  - Back-to-back accesses always pass through one IDLE cycle, so mem_en_o drops for one cycle between grants.
- Requester drops its request while granted (protocol violation): no ack; return to IDLE next edge; mem_* outputs go to 0 combinationally.
- Simultaneous ireq_i/dreq_i with wait_cnt < MAX_WAIT: D wins.
- mem_busy_i high in IDLE: ignored.
- wait_cnt saturates at 15 and never wraps.
- Reset asserted mid-grant: access abandoned, no ack, no write (mem_wen_o forced to 0 asynchronously).
- Busy during a read never times out; the arbiter stays in the grant state.

Decomposition:
- Package mem_arb_pkg: state enum arb_state_t {IDLE, GNT_I, GNT_D}, and a width constant for wait_cnt.
- No sub-module required.
- Optional helper mem_arb_starve_cnt (saturating counter with clear) if reused by a later 3-requester version.

Test Plan:
- Lone fetch: ireq_i = 1, iaddr_i = 0x10, mem busy never asserted, mem_rdata_i = 0xDEADBEEF.
  -> Grant cycle 1 after request; iack_o = 1 and irdata_o = 0xDEADBEEF that cycle; IDLE next.
- Busy stall: dreq_i = 1, dwe_i = 0, daddr_i = 0x4000, mem_busy_i = 1 for 2 grant cycles.
  -> mem_en_o = 1 for 3 cycles; dack_o only in the 3rd; drdata_o = 0 before dack_o.
- Write: dreq_i = 1, dwe_i = 1, daddr_i = 0x4004, dwdata_i = 0x12345678, mem_busy_i = 1.
  -> mem_wen_o = 1 and dack_o = 1 for exactly one cycle; busy ignored.
- Starvation: ireq_i and dreq_i both held continuously, MAX_WAIT = 4.
  -> 4 consecutive D grants, then an I grant; pattern repeats; no requester ever waits more than 5 grants.
- Simultaneous first request: both requests asserted in the same cycle with wait_cnt = 0.
  -> D granted first; I granted on the following arbitration.
- Reset mid-read: rst_i pulsed in GNT_D while mem_busy_i = 1.
  -> All outputs 0 immediately; state IDLE; no dack_o after reset is released unless dreq_i is still asserted, in which case it is a fresh 2-cycle access.
